// File: rtl/maria_line_ram.sv
// Double-buffered 160-cell line RAM: unpacks DMA graphics bytes into cells, display side reads with clear.
// Latency: 4 (2bpp) or 2 (4bpp) cycles capture-to-last-write, reads 1 cycle; no backpressure, bytes landing mid-unpack are dropped.
module maria_line_ram #(
    parameter int CELLS  = 160,
    parameter int CELL_W = 5
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              mclk0,
    input  logic              latch_byte,
    input  logic [7:0]        data_in,
    input  logic              clear_hpos,
    input  logic [7:0]        hpos_in,
    input  logic              wm,
    input  logic [2:0]        pal_in,
    input  logic              kangaroo,
    input  logic              lrc,
    input  logic              rd_en,
    input  logic [7:0]        rd_addr,
    output logic [CELL_W-1:0] rd_data,
    output logic              busy,
    output logic              wr_bank
);

    typedef enum logic {ST_IDLE, ST_UNPACK} state_t;

    state_t              state_q, state_d;
    logic [7:0]          ptr_q, ptr_d;
    logic [7:0]          byte_q, byte_d;
    logic                wm_q, wm_d;
    logic [2:0]          pal_q, pal_d;
    logic                kang_q, kang_d;
    logic                bank_q, bank_d;
    logic [1:0]          pix_q, pix_d;
    logic                wr_bank_q, wr_bank_d;
    logic                clr_hpos_dly_q, clr_hpos_dly_d;
    logic                latch_dly_q, latch_dly_d;
    logic                overrun_q, overrun_d;
    logic [CELL_W-1:0]   rd_data_q, rd_data_d;

    logic [CELL_W-1:0]   mem [2][CELLS];

    logic                latch_rise;
    logic                hpos_load;
    logic [1:0]          color;
    logic [2:0]          pix_pal;
    logic                last_pix;
    logic                wr_en;
    logic                clr_en;

    always_comb begin
        latch_rise = mclk0 & latch_byte & ~latch_dly_q;
        hpos_load  = mclk0 & ~clear_hpos & clr_hpos_dly_q;

        // Most significant pixel first.
        case (pix_q)
            2'd0:    color = byte_q[7:6];
            2'd1:    color = byte_q[5:4];
            2'd2:    color = byte_q[3:2];
            default: color = byte_q[1:0];
        endcase

        // 4bpp takes the low palette bits from the byte's low nibble.
        if (wm_q)
            pix_pal = {pal_q[2], (pix_q[0] ? byte_q[1:0] : byte_q[3:2])};
        else
            pix_pal = pal_q;

        last_pix = wm_q ? (pix_q == 2'd1) : (pix_q == 2'd3);
        wr_en    = ~reset && (state_q == ST_UNPACK) && (ptr_q < 8'(CELLS))
                   && ((color != 2'd0) || kang_q);
        clr_en   = ~reset && rd_en && (rd_addr < 8'(CELLS));
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        byte_d         = byte_q;
        wm_d           = wm_q;
        pal_d          = pal_q;
        kang_d         = kang_q;
        bank_d         = bank_q;
        pix_d          = pix_q;
        wr_bank_d      = wr_bank_q;
        clr_hpos_dly_d = clr_hpos_dly_q;
        latch_dly_d    = latch_dly_q;
        overrun_d      = overrun_q;
        rd_data_d      = rd_data_q;

        if (mclk0) begin
            clr_hpos_dly_d = clear_hpos;
            latch_dly_d    = latch_byte;
        end

        case (state_q)
            ST_IDLE: begin
                if (latch_rise) begin
                    byte_d  = data_in;
                    wm_d    = wm;
                    pal_d   = pal_in;
                    kang_d  = kangaroo;
                    bank_d  = wr_bank_q;
                    pix_d   = 2'd0;
                    state_d = ST_UNPACK;
                end
            end
            default: begin
                ptr_d = ptr_q + 8'd1;
                pix_d = pix_q + 2'd1;
                if (last_pix)
                    state_d = ST_IDLE;
                if (latch_rise)
                    overrun_d = 1'b1;
            end
        endcase

        if (hpos_load)
            ptr_d = hpos_in;

        if (lrc)
            wr_bank_d = ~wr_bank_q;

        if (rd_en)
            rd_data_d = (rd_addr < 8'(CELLS)) ? mem[~wr_bank_q][rd_addr] : '0;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ptr_q          <= 8'd0;
            byte_q         <= 8'd0;
            wm_q           <= 1'b0;
            pal_q          <= 3'd0;
            kang_q         <= 1'b0;
            bank_q         <= 1'b0;
            pix_q          <= 2'd0;
            wr_bank_q      <= 1'b0;
            clr_hpos_dly_q <= 1'b0;
            latch_dly_q    <= 1'b0;
            overrun_q      <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            byte_q         <= byte_d;
            wm_q           <= wm_d;
            pal_q          <= pal_d;
            kang_q         <= kang_d;
            bank_q         <= bank_d;
            pix_q          <= pix_d;
            wr_bank_q      <= wr_bank_d;
            clr_hpos_dly_q <= clr_hpos_dly_d;
            latch_dly_q    <= latch_dly_d;
            overrun_q      <= overrun_d;
            rd_data_q      <= rd_data_d;
        end
    end

    // Cell storage is deliberately not reset; the display side clears as it reads.
    always_ff @(posedge clk_sys) begin
        if (wr_en)
            mem[bank_q][ptr_q] <= {pix_pal, color};
        if (clr_en)
            mem[~wr_bank_q][rd_addr] <= '0;
    end

    assign rd_data = rd_data_q;
    assign busy    = (state_q == ST_UNPACK);
    assign wr_bank = wr_bank_q;

endmodule

// File: tb/tb_maria_line_ram.sv
module tb_maria_line_ram;

    logic       clk_sys = 1'b0;
    logic       reset, mclk0, latch_byte, clear_hpos, wm, kangaroo, lrc, rd_en;
    logic [7:0] data_in, hpos_in, rd_addr;
    logic [2:0] pal_in;
    logic [4:0] rd_data;
    logic       busy, wr_bank;

    int total = 0;
    int bad   = 0;

    // Reference: two banks of cells, a write pointer and the active write bank.
    logic [4:0] ref_mem [2][160];
    int         ref_ptr;
    bit         ref_bank;

    maria_line_ram dut (
        .clk_sys(clk_sys), .reset(reset), .mclk0(mclk0), .latch_byte(latch_byte),
        .data_in(data_in), .clear_hpos(clear_hpos), .hpos_in(hpos_in), .wm(wm),
        .pal_in(pal_in), .kangaroo(kangaroo), .lrc(lrc), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .wr_bank(wr_bank)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    // Apply the first npix pixels of a byte to the model's current write bank.
    function automatic void model_byte(input int b, input int wmv, input int pal,
                                       input int kang, input int npix);
        int n = (wmv != 0) ? 2 : 4;
        if (npix < n) n = npix;
        for (int k = 0; k < n; k++) begin
            int c = (b >> (6 - 2 * k)) & 3;
            int p = (wmv != 0) ? ((pal & 4) | ((b >> (2 - 2 * k)) & 3)) : pal;
            if (ref_ptr < 160 && (c != 0 || kang != 0))
                ref_mem[ref_bank][ref_ptr] = 5'(p * 4 + c);
            ref_ptr = (ref_ptr + 1) % 256;
        end
    endfunction

    task automatic set_hpos(input int h);
        clear_hpos = 1'b1;
        tick;
        clear_hpos = 1'b0;
        hpos_in    = 8'(h);
        tick;
        ref_ptr = h;
        chk("ptr_load", 32'(dut.ptr_q), 32'(h));
    endtask

    task automatic send_byte(input int b, input int wmv, input int pal, input int kang,
                             input bit lrc_mid);
        int cyc;
        int n = (wmv != 0) ? 2 : 4;
        data_in    = 8'(b);
        wm         = wmv[0];
        pal_in     = 3'(pal);
        kangaroo   = kang[0];
        latch_byte = 1'b1;
        tick;
        latch_byte = 1'b0;
        model_byte(b, wmv, pal, kang, 4);
        chk("busy_cap", 32'(busy), 32'd1);
        cyc = 0;
        if (lrc_mid) begin
            lrc = 1'b1;
            tick;
            lrc = 1'b0;
            ref_bank = !ref_bank;
            cyc = 1;
            chk("wr_bank_mid", 32'(wr_bank), 32'(ref_bank));
        end
        while (busy === 1'b1 && cyc < 8) begin
            tick;
            cyc++;
        end
        chk("unpack_len", 32'(cyc), 32'(n));
        chk("ptr_adv", 32'(dut.ptr_q), 32'(ref_ptr));
    endtask

    task automatic rd_chk(input int a, input logic [4:0] exp);
        rd_en   = 1'b1;
        rd_addr = 8'(a);
        tick;
        rd_en = 1'b0;
        chk($sformatf("cell%0d", a), 32'(rd_data), 32'(exp));
        ref_mem[!ref_bank][a] = 5'd0;
    endtask

    task automatic read_pass;
        logic [4:0] last;
        for (int a = 0; a < 160; a++) begin
            rd_en   = 1'b1;
            rd_addr = 8'(a);
            last    = ref_mem[!ref_bank][a];
            tick;
            chk($sformatf("rd%0d", a), 32'(rd_data), 32'(last));
            ref_mem[!ref_bank][a] = 5'd0;
        end
        rd_en   = 1'b0;
        rd_addr = 8'd3;
        tick;
        chk("rd_hold", 32'(rd_data), 32'(last));
        rd_en   = 1'b1;
        rd_addr = 8'($urandom_range(160, 255));
        tick;
        rd_en = 1'b0;
        chk("rd_oob", 32'(rd_data), 32'd0);
    endtask

    task automatic read_nocheck;
        for (int a = 0; a < 160; a++) begin
            rd_en   = 1'b1;
            rd_addr = 8'(a);
            tick;
            ref_mem[!ref_bank][a] = 5'd0;
        end
        rd_en = 1'b0;
        tick;
    endtask

    task automatic swap(input bit do_rd);
        int a = $urandom_range(0, 159);
        logic [4:0] e = ref_mem[!ref_bank][a];
        lrc = 1'b1;
        if (do_rd) begin
            rd_en   = 1'b1;
            rd_addr = 8'(a);
        end
        tick;
        lrc   = 1'b0;
        rd_en = 1'b0;
        if (do_rd) begin
            chk("rd_swap", 32'(rd_data), 32'(e));
            ref_mem[!ref_bank][a] = 5'd0;
        end
        ref_bank = !ref_bank;
        chk("wr_bank", 32'(wr_bank), 32'(ref_bank));
    endtask

    task automatic rand_writer(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            if ($urandom_range(0, 2) == 0)
                set_hpos($urandom_range(0, 255));
            send_byte($urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 7),
                      $urandom_range(0, 1), 1'b0);
        end
    endtask

    initial begin
        int cyc;
        reset = 1'b1; mclk0 = 1'b1; latch_byte = 1'b0; clear_hpos = 1'b0; wm = 1'b0;
        kangaroo = 1'b0; lrc = 1'b0; rd_en = 1'b0; data_in = 8'd0; hpos_in = 8'd0;
        rd_addr = 8'd0; pal_in = 3'd0;
        ref_ptr = 0; ref_bank = 1'b0;
        tick; tick;
        reset = 1'b0;
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_bank", 32'(wr_bank), 32'd0);
        chk("rst_ptr", 32'(dut.ptr_q), 32'd0);
        chk("rst_overrun", 32'(dut.overrun_q), 32'd0);

        // Scrub both banks so the model starts from known contents.
        read_nocheck; swap(1'b0);
        read_nocheck; swap(1'b0);

        // Directed writes into bank 0.
        set_hpos(10);  send_byte(8'hE4, 0, 5, 0, 1'b0);
        chk("ptr_2bpp", 32'(dut.ptr_q), 32'd14);
        set_hpos(10);  send_byte(8'hE4, 0, 5, 1, 1'b0);
        set_hpos(20);  send_byte(8'hB6, 1, 4, 0, 1'b0);
        chk("ptr_4bpp", 32'(dut.ptr_q), 32'd22);
        set_hpos(158); send_byte(8'hFF, 0, 2, 0, 1'b0);
        chk("ptr_edge", 32'(dut.ptr_q), 32'd162);
        set_hpos(254); send_byte(8'hFF, 0, 3, 0, 1'b0);
        chk("ptr_wrap", 32'(dut.ptr_q), 32'd2);
        swap(1'b0);
        rd_chk(10, 5'b10111); rd_chk(11, 5'b10110); rd_chk(12, 5'b10101);
        rd_chk(13, 5'b10100); rd_chk(20, 5'b10110); rd_chk(21, 5'b11011);
        rd_chk(158, 5'b01011); rd_chk(159, 5'b01011);
        rd_chk(0, 5'b01111); rd_chk(1, 5'b01111);
        rd_chk(2, 5'b00000); rd_chk(14, 5'b00000);
        read_pass;
        read_pass;

        // Swap in the middle of an unpack: the byte stays in the bank it started in.
        set_hpos(30);
        send_byte(8'h9C, 0, 7, 0, 1'b1);
        read_pass;

        // Concurrent display reads and unpacker writes on opposite banks.
        for (int r = 0; r < 6; r++) begin
            fork
                read_pass;
                rand_writer($urandom_range(4, 12));
            join
            swap(1'b1);
        end

        // Latch while mclk0 is low must not capture.
        mclk0 = 1'b0; latch_byte = 1'b1;
        tick; tick;
        chk("gated_latch", 32'(busy), 32'd0);
        latch_byte = 1'b0; mclk0 = 1'b1;
        tick;

        // Second byte during unpack with a slow Maria clock is dropped.
        set_hpos(50);
        data_in = 8'h55; wm = 1'b0; pal_in = 3'd6; kangaroo = 1'b0; latch_byte = 1'b1;
        tick;
        model_byte(8'h55, 0, 6, 0, 4);
        latch_byte = 1'b0; mclk0 = 1'b0;
        tick;
        mclk0 = 1'b1;
        tick;
        data_in = 8'hAA; latch_byte = 1'b1;
        tick;
        latch_byte = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 8) begin
            tick;
            cyc++;
        end
        chk("overrun_busy_drop", 32'(busy), 32'd0);
        chk("overrun", 32'(dut.overrun_q), 32'd1);
        chk("ptr_overrun", 32'(dut.ptr_q), 32'(ref_ptr));

        // Reset after the first pixel of a byte: only that pixel survives.
        set_hpos(40);
        data_in = 8'hFF; wm = 1'b0; pal_in = 3'd1; kangaroo = 1'b0; latch_byte = 1'b1;
        tick;
        latch_byte = 1'b0;
        tick;
        model_byte(8'hFF, 0, 1, 0, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        ref_bank = 1'b0;
        ref_ptr  = 0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_wr_bank", 32'(wr_bank), 32'd0);
        chk("rst_mid_ptr", 32'(dut.ptr_q), 32'd0);
        chk("rst_mid_rd_data", 32'(rd_data), 32'd0);
        chk("rst_mid_overrun", 32'(dut.overrun_q), 32'd0);
        tick; tick;
        chk("rst_mid_idle", 32'(busy), 32'd0);

        swap(1'b1); read_pass;
        swap(1'b1); read_pass;
        read_pass;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
